alu_iter_exec: RTL and testbench

Iterative execute-stage ALU that consumes the 6-bit ALU control code produced by the EX-stage ALU control decoder, together with the two operands and the shift amount. Logic and arithmetic codes complete in one cycle. Shift codes run one bit position per cycle through an internal shifter, so no barrel shifter is needed. A valid/ready handshake on both sides lets the pipeline hazard unit stall while a shift is in flight.

---
 rtl/alu_iter_exec.sv | 144 ++++++++++++++
 tb/tb_alu_iter_exec.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: logic/arithmetic ops finish in one cycle, shifts walk one
// bit per cycle through a single-position shifter. valid/ready on both sides.
module alu_iter_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         alu_op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_SLT = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_NOR = 6'd6;
  localparam logic [5:0] OP_SLL = 6'd7;
  localparam logic [5:0] OP_SRL = 6'd8;
  localparam logic [5:0] OP_SRA = 6'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

  state_t             state, state_nxt;
  shift_t             sh_kind, sh_kind_nxt;
  logic [WIDTH-1:0]   sh_reg, sh_reg_nxt, sh_step, alu_val;
  logic [WIDTH-1:0]   result_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic               zero_nxt, illegal_nxt, is_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign is_shift  = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

  always_comb begin
    alu_val = '0;
    case (alu_op)
      OP_ADD:  alu_val = src_a + src_b;
      OP_SUB:  alu_val = src_a - src_b;
      OP_AND:  alu_val = src_a & src_b;
      OP_OR:   alu_val = src_a | src_b;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_XOR:  alu_val = src_a ^ src_b;
      OP_NOR:  alu_val = ~(src_a | src_b);
      default: alu_val = '0;
    endcase
  end

  always_comb begin
    sh_step = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
    case (sh_kind)
      SH_LL:   sh_step = {sh_reg[WIDTH-2:0], 1'b0};
      SH_RL:   sh_step = {1'b0, sh_reg[WIDTH-1:1]};
      default: sh_step = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_nxt   = state;
    sh_kind_nxt = sh_kind;
    sh_reg_nxt  = sh_reg;
    cnt_nxt     = cnt;
    result_nxt  = result;
    zero_nxt    = zero;
    illegal_nxt = illegal;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            sh_reg_nxt = src_b;
            cnt_nxt    = shamt;
            case (alu_op)
              OP_SLL:  sh_kind_nxt = SH_LL;
              OP_SRL:  sh_kind_nxt = SH_RL;
              default: sh_kind_nxt = SH_RA;
            endcase
            state_nxt = SHIFT;
          end else if (is_shift) begin
            result_nxt  = src_b;
            zero_nxt    = (src_b == '0);
            illegal_nxt = 1'b0;
            state_nxt   = DONE;
          end else begin
            // Illegal codes fall into the default arm of alu_val, giving 0.
            result_nxt  = alu_val;
            zero_nxt    = (alu_val == '0);
            illegal_nxt = (alu_op > OP_SRA);
            state_nxt   = DONE;
          end
        end
      end
      SHIFT: begin
        sh_reg_nxt = sh_step;
        cnt_nxt    = cnt - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          result_nxt  = sh_step;
          zero_nxt    = (sh_step == '0);
          illegal_nxt = 1'b0;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh_kind <= SH_LL;
      sh_reg  <= '0;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      sh_kind <= sh_kind_nxt;
      sh_reg  <= sh_reg_nxt;
      cnt     <= cnt_nxt;
      result  <= result_nxt;
      zero    <= zero_nxt;
      illegal <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: scenario tasks drive requests, a reference model
// fills exp_q on issue, and results are popped when out_valid appears.
module tb_alu_iter_exec;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int EW      = WIDTH + 2;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         alu_op;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               illegal;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {illegal, zero, result}
  logic [EW-1:0] exp_q[$];

  alu_iter_exec #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] model(input logic [5:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] sh);
    logic [WIDTH-1:0] r;
    logic             ill;
    ill = 1'b0;
    case (op)
      6'd0: r = a + b;
      6'd1: r = a - b;
      6'd2: r = a & b;
      6'd3: r = a | b;
      6'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd5: r = a ^ b;
      6'd6: r = ~(a | b);
      6'd7: r = b << sh;
      6'd8: r = b >> sh;
      6'd9: r = $signed(b) >>> sh;
      default: begin r = '0; ill = 1'b1; end
    endcase
    return {ill, (r == '0), r};
  endfunction

  function automatic int lat_of(input logic [5:0] op, input logic [SHAMT_W-1:0] sh);
    if (op >= 6'd7 && op <= 6'd9) return int'(sh) + 1;
    return 1;
  endfunction

  // Drives a request at a negedge and returns right after the accepting posedge.
  task automatic issue(input logic [5:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] sh, input bit push);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL issue_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    alu_op = op; src_a = a; src_b = b; shamt = sh; in_valid = 1'b1;
    if (push) exp_q.push_back(model(op, a, b, sh));
    @(posedge clk);
  endtask

  // Waits for out_valid while toggling noise on the inputs, checks latency and
  // data, optionally back-pressures for hold cycles, then completes the handshake.
  task automatic collect(input int exp_lat, input int hold, input string name);
    int            lat = 0;
    bit            seen = 0;
    bit            busy_bad = 0;
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      in_valid = 1'b1;
      alu_op = 6'($urandom_range(0, 63));
      src_a = $urandom; src_b = $urandom; shamt = SHAMT_W'($urandom);
      if (out_valid === 1'b1) begin
        seen = 1;
        out_ready = (hold == 0);
      end else begin
        if (in_ready !== 1'b0) busy_bad = 1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    total_cnt++;
    if (!seen) begin
      $display("FAIL %s_timeout: out_valid not seen within %0d cycles", name, lat);
      out_ready = 1'b1; in_valid = 1'b0;
      return;
    end
    pass_cnt++;
    total_cnt++;
    if (lat != exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad) $display("FAIL %s_busy_in_ready: got 1 want 0 while busy", name);
    else pass_cnt++;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    got = {illegal, zero, result};
    total_cnt++;
    if (got !== exp_v) $display("FAIL %s_data: got %h want %h", name, got, exp_v);
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_op = 6'($urandom_range(0, 9)); src_b = $urandom;
      got = {illegal, zero, result};
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== exp_v)
        $display("FAIL %s_hold%0d: got v=%b r=%b d=%h want v=1 r=0 d=%h",
                 name, i, out_valid, in_ready, got, exp_v);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s_release: got in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; src_a = '0; src_b = '0; shamt = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b0 || illegal !== 1'b0)
      $display("FAIL reset_outputs: got ir=%b ov=%b res=%h z=%b ill=%b want 1 0 0 0 0",
               in_ready, out_valid, result, zero, illegal);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_first_cycle: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_add();
    issue(6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1);
    collect(1, 0, "add_wrap");
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL add_queue: got %0d entries want 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_slt();
    issue(6'd4, 32'h8000_0000, 32'd1, 5'd3, 1);
    collect(1, 0, "slt_neg");
    issue(6'd4, 32'd1, 32'h8000_0000, 5'd3, 1);
    collect(1, 0, "slt_pos");
  endtask

  task automatic test_logic();
    for (int i = 0; i < 7; i++) begin
      issue(6'(i), $urandom, $urandom, SHAMT_W'($urandom), 1);
      collect(1, 0, "logic_op");
    end
  endtask

  task automatic test_sra();
    issue(6'd9, 32'd0, 32'h8000_0010, 5'd4, 1);
    collect(5, 0, "sra4");
  endtask

  task automatic test_shift_edges();
    issue(6'd7, 32'd0, 32'h0000_1234, 5'd0, 1);
    collect(1, 0, "sll0");
    issue(6'd8, 32'd0, 32'h8000_0000, 5'd31, 1);
    collect(32, 0, "srl31");
    issue(6'd9, 32'd0, 32'h7000_0000, 5'd31, 1);
    collect(32, 0, "sra31_pos");
  endtask

  task automatic test_backpressure_illegal();
    issue(6'd12, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 1);
    collect(1, 10, "illegal12");
    issue(6'd63, 32'd5, 32'd6, 5'd1, 1);
    collect(1, 3, "illegal63");
  endtask

  task automatic test_back_to_back();
    logic [5:0]         op;
    logic [SHAMT_W-1:0] sh;
    for (int i = 0; i < 10; i++) begin
      op = 6'($urandom_range(0, 11));
      sh = SHAMT_W'($urandom_range(0, 12));
      issue(op, $urandom, $urandom, sh, 1);
      collect(lat_of(op, sh), 0, "b2b");
    end
  endtask

  task automatic test_reset_mid_shift();
    bit rose = 0;
    issue(6'd7, 32'd0, 32'hFFFF_FFFF, 5'd20, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || illegal !== 1'b0)
      $display("FAIL midshift_reset: got ov=%b ir=%b res=%h ill=%b want 0 1 0 0",
               out_valid, in_ready, result, illegal);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) rose = 1;
    end
    total_cnt++;
    if (rose) $display("FAIL midshift_no_output: got out_valid/in_ready change want idle");
    else pass_cnt++;
    issue(6'd1, 32'd10, 32'd3, 5'd0, 1);
    collect(1, 0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_add();
    test_slt();
    test_logic();
    test_sra();
    test_shift_edges();
    test_backpressure_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d entries want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
